serial_paralelo_rx: RTL
=======================

// Module: serial_paralelo_rx
// PURPOSE
// - Receive-side stage directly downstream of paralelo_serial; consumes its 1-bit MSB-first serial stream.
// - Finds byte boundaries by hunting the COM symbol (0xBC) and locks after COM_COUNT consecutive aligned COMs.
// - Once locked, it deserializes bytes and strips idle COMs. It presents data bytes as data_out/valid_out.
// - Single clock domain (clk_32f); the byte rate is derived internally with a 3-bit phase counter.
// PARAMETERS
// - COM        8'hBC  comma/idle symbol used for alignment and idle fill
// - COM_COUNT  4      consecutive boundary-aligned COMs required to assert active (legal 2..15)
// PORTS
// - clk_32f    in   1  bit clock; all state updates on posedge
// - reset_L    in   1  synchronous, active-low reset, sampled on posedge clk_32f
// - data_in    in   1  serial bit, MSB first, one bit per clk_32f
// - data_out   out  8  last received non-COM byte
// - valid_out  out  1  data_out holds a fresh data byte for the current byte period
// - active     out  1  receiver locked (COM_COUNT aligned COMs seen)
// - byte_count out  8  only with SP_BYTE_COUNT_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset (reset_L==0 at posedge): data_out=8'h00, valid_out=0, active=0, sr=8'h00, phase=0, com_cnt=0, state=SEARCH.
// - Reset wins over all other events and applies mid-byte. Lock and phase are lost.
// - Shift register: every posedge, sr <= {sr[6:0], data_in}. The sr compare uses the registered value.
// - Boundary cycle: a cycle in which sr holds one complete byte. Boundaries are spaced exactly 8 cycles apart once phase is set.
// - FSM states: SEARCH, ALIGN, ACTIVE.
//   - SEARCH: bit-level hunt. The first cycle with sr==COM defines the boundary.
//     Actions: phase<=1, com_cnt<=1, state<=ALIGN.
//   - ALIGN: phase increments mod 8. At each boundary (phase==0):
//     - sr==COM: com_cnt++. When it reaches COM_COUNT, state<=ACTIVE and active<=1 on that same edge.
//     - sr!=COM: com_cnt<=0, state<=SEARCH. The hunt resumes on the next cycle.
//   - ACTIVE: phase increments mod 8. At each boundary:
//     - sr!=COM: data_out<=sr, valid_out<=1.
//     - sr==COM: valid_out<=0, data_out holds.
//   - ACTIVE: outputs update only at boundaries, so each value is held for 8 cycles (clk_4f-equivalent level).
//   - ACTIVE is left only by reset. No loss-of-lock detection.
// - Latency: the last bit of a byte sampled at edge N produces data_out/valid_out at edge N+1.
//   This is 9 cycles from the first bit of that byte.
// - COM pattern straddling two bytes in SEARCH: it is accepted as a boundary. If the next boundary is not COM, ALIGN rejects it and returns to SEARCH.
// - The boundary that completes the lock carries a COM, so valid_out stays 0 on that edge. The first data byte can appear at the next boundary.
// - active, valid_out and data_out are all registered. Outputs have no combinational paths from inputs.
// CONFIGURATION
// - SP_BYTE_COUNT_EN defined: adds output byte_count[7:0] (reset 0).
//   It increments on each boundary where valid_out is set to 1 and wraps 255->0.
// - SP_BYTE_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
// - Lock: reset_L=0 for 2 cycles, then 4x 0xBC -> active rises at the edge after the 32nd bit.
//   valid_out stays 0 and data_out stays 0x00.
// - Data: after lock, send 0x55,0xBC,0xAA -> data_out=0x55/valid=1 for 8 cycles.
//   Then valid=0 with data_out=0x55 for 8 cycles, then data_out=0xAA/valid=1.
// - Bit slip: 3 random bits, then 4x 0xBC, then 0x3C.
//   Expected: locks on the correct phase; data_out=0x3C, valid=1.
// - Broken preamble: 0xBC,0xBC,0xBC,0x12, then 4x 0xBC -> active stays 0 through the 0x12.
//   It re-locks only after the later 4 COMs.
// - Reset mid-byte: while active, drive reset_L=0 at bit 4 of a data byte.
//   Expected: all outputs 0 next edge, and no valid until a fresh 4-COM lock.
// - SP_BYTE_COUNT_EN: after lock, send 258 data bytes -> byte_count==2, having wrapped through 255->0.

Source files
------------

// File: rtl/serial_paralelo_rx.sv
// -----------------------------------------------------------------------------
// serial_paralelo_rx
//
// Purpose:
//   Receive-side deserializer for the MSB-first serial stream that
//   paralelo_serial produces. It hunts for the COM symbol bit by bit to find
//   byte boundaries. After COM_COUNT consecutive boundary-aligned COMs it
//   locks. Once locked it presents every non-COM byte on data_out/valid_out.
//   Idle COMs are dropped.
//
// Parameters:
//   COM        comma / idle symbol used for alignment (default 8'hBC)
//   COM_COUNT  aligned COMs needed to lock, legal range 2..15 (default 4)
//
// Ports:
//   clk_32f     in   bit clock, all state changes on its rising edge
//   reset_L     in   synchronous active-low reset
//   data_in     in   serial bit, MSB first, one bit per clk_32f
//   data_out    out  [7:0] last received non-COM byte
//   valid_out   out  data_out holds a fresh data byte for this byte period
//   active      out  receiver locked
//   byte_count  out  [7:0] count of data bytes delivered, wraps 255->0
//                    (present only when SP_BYTE_COUNT_EN is defined)
//
// Build option:
//   SP_BYTE_COUNT_EN  when defined, adds the byte_count output and counter.
// -----------------------------------------------------------------------------
module serial_paralelo_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SP_BYTE_COUNT_EN
    ,
    output logic [7:0] byte_count
`endif
);

    localparam logic [3:0] COM_COUNT_W = 4'(COM_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] sr_reg, sr_next;
    logic [2:0] phase_reg, phase_next;
    logic [3:0] com_cnt_reg, com_cnt_next;
    logic [7:0] data_out_reg, data_out_next;
    logic       valid_reg, valid_next;
    logic       active_reg, active_next;
`ifdef SP_BYTE_COUNT_EN
    logic [7:0] byte_count_reg, byte_count_next;
`endif

    // A boundary is the cycle in which sr_reg holds one complete byte.
    logic boundary;
    logic sr_is_com;

    assign boundary  = (phase_reg == 3'd0);
    assign sr_is_com = (sr_reg == COM);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_reg      <= SEARCH;
            sr_reg         <= 8'h00;
            phase_reg      <= 3'd0;
            com_cnt_reg    <= 4'd0;
            data_out_reg   <= 8'h00;
            valid_reg      <= 1'b0;
            active_reg     <= 1'b0;
`ifdef SP_BYTE_COUNT_EN
            byte_count_reg <= 8'h00;
`endif
        end else begin
            state_reg      <= state_next;
            sr_reg         <= sr_next;
            phase_reg      <= phase_next;
            com_cnt_reg    <= com_cnt_next;
            data_out_reg   <= data_out_next;
            valid_reg      <= valid_next;
            active_reg     <= active_next;
`ifdef SP_BYTE_COUNT_EN
            byte_count_reg <= byte_count_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        sr_next         = {sr_reg[6:0], data_in};
        // 3-bit counter wraps naturally, giving the mod-8 byte phase.
        phase_next      = phase_reg + 3'd1;
        com_cnt_next    = com_cnt_reg;
        data_out_next   = data_out_reg;
        valid_next      = valid_reg;
        active_next     = active_reg;
`ifdef SP_BYTE_COUNT_EN
        byte_count_next = byte_count_reg;
`endif

        unique case (state_reg)
            SEARCH: begin
                // Bit-level hunt. The cycle where sr matches COM is a boundary.
                // Starting the phase at 1 lands the next boundary 8 cycles later.
                phase_next = 3'd0;
                if (sr_is_com) begin
                    phase_next   = 3'd1;
                    com_cnt_next = 4'd1;
                    state_next   = ALIGN;
                end
            end

            ALIGN: begin
                if (boundary) begin
                    if (sr_is_com) begin
                        com_cnt_next = com_cnt_reg + 4'd1;
                        if ((com_cnt_reg + 4'd1) == COM_COUNT_W) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                        end
                    end else begin
                        // The candidate boundary was wrong (for example, a COM
                        // that straddled two bytes). Resume the hunt.
                        com_cnt_next = 4'd0;
                        state_next   = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                // Outputs change only at boundaries, so each value is held
                // for a full byte period. Only reset leaves this state.
                if (boundary) begin
                    if (!sr_is_com) begin
                        data_out_next = sr_reg;
                        valid_next    = 1'b1;
`ifdef SP_BYTE_COUNT_EN
                        byte_count_next = byte_count_reg + 8'd1;
`endif
                    end else begin
                        valid_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    assign data_out  = data_out_reg;
    assign valid_out = valid_reg;
    assign active    = active_reg;
`ifdef SP_BYTE_COUNT_EN
    assign byte_count = byte_count_reg;
`endif

endmodule
